// File: rtl/present_pkg.sv
// PRESENT-80 shared definitions: widths, controller state encoding and the
// round primitives (S-box, bit permutation, key schedule) used by every core
// variant, so the full core and the split half-cores stay bit-identical.
package present_pkg;

  localparam int KEY_W        = 80;
  localparam int BLK_W        = 64;
  localparam int ROUNDS       = 31;
  // Bit i of the state moves to (i * PERM_STRIDE) mod 63; bit 63 stays put.
  localparam int PERM_STRIDE  = 16;
  // Last round of the first half when the core is split in two.
  localparam int SPLIT_ROUND  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // 4-bit PRESENT S-box.
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox4(s[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    r[63] = s[63];
    for (int i = 0; i < 63; i++) r[(i * PERM_STRIDE) % 63] = s[i];
    return r;
  endfunction

  // One full round: add round key (top 64 key bits), substitute, permute.
  function automatic logic [BLK_W-1:0] round_fn(input logic [BLK_W-1:0] s,
                                                input logic [KEY_W-1:0] k);
    return p_layer(sbox_layer(s ^ k[79:16]));
  endfunction

  // Key register update after round rc: rotate left 61, S-box top nibble,
  // XOR round counter into bits 19..15.
  function automatic logic [KEY_W-1:0] key_sched(input logic [KEY_W-1:0] k,
                                                 input logic [4:0] rc);
    logic [KEY_W-1:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox4(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

endpackage

// File: rtl/encrypt_v1.sv
// Fully combinational PRESENT-80 encryption core: C = PRESENT(K, M).
// Built from two back-to-back half-core slices with no register between them.
module encrypt_v1
  import present_pkg::*;
(
  input  logic [BLK_W-1:0] M,
  input  logic [KEY_W-1:0] K,
  output logic [BLK_W-1:0] C
);

  logic [BLK_W-1:0] mid_s;

  present_half_core #(.FIRST(1), .LAST(SPLIT_ROUND), .FINAL_ADD(1'b0)) u_lo (
    .state_in  (M),
    .key       (K),
    .state_out (mid_s)
  );

  present_half_core #(.FIRST(SPLIT_ROUND + 1), .LAST(ROUNDS), .FINAL_ADD(1'b1)) u_hi (
    .state_in  (mid_s),
    .key       (K),
    .state_out (C)
  );

endmodule

// File: rtl/present_half_core.sv
// Combinational slice of PRESENT-80 covering rounds FIRST..LAST. The slice
// re-derives its starting round key from the master key, so consecutive
// slices only need the state passed between them (the key is held stable
// by the controller for the whole chain). FINAL_ADD applies the closing
// round-key addition after the last round.
module present_half_core
  import present_pkg::*;
#(
  parameter int FIRST     = 1,
  parameter int LAST      = ROUNDS,
  parameter bit FINAL_ADD = 1'b1
) (
  input  logic [BLK_W-1:0] state_in,
  input  logic [KEY_W-1:0] key,
  output logic [BLK_W-1:0] state_out
);

  logic [BLK_W-1:0] s;
  logic [KEY_W-1:0] k;

  // Fast-forward the key schedule, then run this slice's rounds.
  always_comb begin
    k = key;
    for (int r = 1; r < FIRST; r++) k = key_sched(k, 5'(r));
    s = state_in;
    for (int r = FIRST; r <= LAST; r++) begin
      s = round_fn(s, k);
      k = key_sched(k, 5'(r));
    end
    state_out = FINAL_ADD ? (s ^ k[79:16]) : s;
  end

endmodule

// File: rtl/present_cbc_ctrl.sv
// CBC-mode controller in front of the PRESENT-80 core. One chain at a time:
// start captures key and IV, plaintext blocks are XORed with the chaining
// value and encrypted, ciphertext is returned from a single output register.
// Optional build macro: PRESENT_CBC_MIDREG_EN inserts a pipeline register
// after round 15 (2-cycle latency, one block per two cycles).
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high; a source holds valid and its data stable until that edge, and
// ready may depend on the other side's state but never drops a held block.
module present_cbc_ctrl
  import present_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic [BLK_W-1:0] iv_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  state_t           state;
  logic [KEY_W-1:0] key_q;
  logic [BLK_W-1:0] chain_q;
  logic [BLK_W-1:0] core_m;
  logic [BLK_W-1:0] ct;
  logic             accept;
  logic             take;

  assign core_m = in_data ^ chain_q;
  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;
  assign busy   = (state != IDLE);

`ifdef PRESENT_CBC_MIDREG_EN
  logic [BLK_W-1:0] half_s;
  logic [BLK_W-1:0] mid_q;
  logic             mid_valid;
  logic             mid_last;
  logic             mid_move;

  present_half_core #(.FIRST(1), .LAST(SPLIT_ROUND), .FINAL_ADD(1'b0)) u_lo (
    .state_in  (core_m),
    .key       (key_q),
    .state_out (half_s)
  );

  present_half_core #(.FIRST(SPLIT_ROUND + 1), .LAST(ROUNDS), .FINAL_ADD(1'b1)) u_hi (
    .state_in  (mid_q),
    .key       (key_q),
    .state_out (ct)
  );

  // The mid stage advances whenever the output register is free or draining.
  assign mid_move = mid_valid & (~out_valid | out_ready);

  // Accept only with an empty mid stage: the next block needs this one's
  // ciphertext as its chaining value.
  always_comb begin
    in_ready = 1'b0;
    if (state == RUN) in_ready = ~mid_valid & (~out_valid | out_ready);
  end
`else
  encrypt_v1 u_core (
    .M (core_m),
    .K (key_q),
    .C (ct)
  );

  // Output register refills in the same cycle it drains.
  always_comb begin
    in_ready = 1'b0;
    if (state == RUN) in_ready = ~out_valid | out_ready;
  end
`endif

  // Chain FSM together with the datapath registers it owns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_q     <= '0;
      chain_q   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      blk_cnt   <= '0;
`ifdef PRESENT_CBC_MIDREG_EN
      mid_q     <= '0;
      mid_valid <= 1'b0;
      mid_last  <= 1'b0;
`endif
    end else begin
      if (take) out_valid <= 1'b0;
`ifdef PRESENT_CBC_MIDREG_EN
      if (mid_move) begin
        out_valid <= 1'b1;
        out_data  <= ct;
        out_last  <= mid_last;
        chain_q   <= ct;
        mid_valid <= 1'b0;
      end
      if (accept) begin
        mid_valid <= 1'b1;
        mid_q     <= half_s;
        mid_last  <= in_last;
      end
`else
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= ct;
        out_last  <= in_last;
        chain_q   <= ct;
      end
`endif
      if (accept && (blk_cnt != '1)) blk_cnt <= blk_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            key_q   <= key_in;
            chain_q <= iv_in;
            blk_cnt <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (accept && in_last) state <= DRAIN;
        end
        DRAIN: begin
`ifdef PRESENT_CBC_MIDREG_EN
          if (take && out_last && !mid_valid) state <= IDLE;
`else
          if (take && out_last) state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/present_cbc_ctrl.md
# present_cbc_ctrl

Sequential CBC-mode controller placed directly upstream of the team's combinational PRESENT-80 core (`encrypt_v1`). It accepts a stream of 64-bit plaintext blocks over a valid/ready handshake and XORs each block with the chaining value (IV, then the previous ciphertext). It drives the core's `M` and `K` inputs and returns registered ciphertext over a second valid/ready handshake. One chain (key + IV + N blocks, terminated by `in_last`) is processed at a time.

## Interface

Parameters:
- `CNT_W`, 16, width of the block counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse; in IDLE, captures `key_in`/`iv_in` and opens a chain.
- `key_in`  in  80  PRESENT-80 key.
- `iv_in`  in  64  initial chaining value.
- `in_valid`  in  1  plaintext block offered.
- `in_ready`  out  1  block accepted when `in_valid & in_ready`.
- `in_data`  in  64  plaintext block.
- `in_last`  in  1  final block of the chain.
- `out_valid`  out  1  ciphertext block available.
- `out_ready`  in  1  consumer takes block when `out_valid & out_ready`.
- `out_data`  out  64  ciphertext block.
- `out_last`  out  1  marks final ciphertext of the chain.
- `busy`  out  1  high in any state other than IDLE.
- `blk_cnt`  out  CNT_W  blocks accepted in the current chain.

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE:
  - `in_ready`=0.
  - On `start`: `key_q`<=`key_in`, `chain_q`<=`iv_in`, `blk_cnt`<=0, go to RUN.
- RUN:
  - `start` is ignored.
  - `in_ready` = !`out_valid` | `out_ready`; the single output register can refill in the same cycle it drains.
  - On accept: ct = PRESENT(`key_q`, `in_data` ^ `chain_q`); `out_data`<=ct, `chain_q`<=ct, `out_valid`<=1, `out_last`<=`in_last`, `blk_cnt`<=`blk_cnt`+1.
  - `blk_cnt` saturates at all-ones and does not wrap.
  - Accept with `in_last`=1: go to DRAIN.
- DRAIN:
  - `in_ready`=0.
  - When the `out_last` block is taken: `out_valid`<=0, go to IDLE.
  - `key_q` and `chain_q` keep their values; `blk_cnt` holds its final count until the next `start`.
- `out_valid` stays high and `out_data` stays stable until taken. A consumer that stalls never loses or changes a block.
- `start` asserted in the same cycle that DRAIN completes is ignored. `start` is sampled only in IDLE.
- Asserting `rst` mid-chain aborts the chain. The in-flight block is discarded with no flush.
- Reset values:
  - State IDLE.
  - `in_ready`, `out_valid`, `out_last`, `busy` = 0.
  - `out_data`, `blk_cnt`, `key_q`, `chain_q` = 0.

## Timing

- Default latency: block accepted at edge n, `out_valid` high after edge n (visible in cycle n+1).
- Throughput: 1 block/cycle when `out_ready` is held high.
- The core path is fully combinational. The critical path is input XOR → 31 rounds → `out_data`/`chain_q` flops.
- `in_ready` depends combinationally on `out_ready`; no other input-to-output combinational path exists.
- `busy` rises the cycle after `start` and falls the cycle after the last output handshake.

## Configuration

- `PRESENT_CBC_MIDREG_EN` defined:
  - Pipeline register after round 15 inside the core path. Latency becomes 2 cycles.
  - CBC dependency limits throughput to 1 block per 2 cycles.
  - `in_ready` is additionally gated low while a block occupies the mid register.
  - DRAIN waits for both stages to empty.
- `PRESENT_CBC_MIDREG_EN` undefined:
  - Single-stage behaviour as above. No mid register is instantiated.

## Structure

- Shared package (`present_pkg`):
  - Widths `KEY_W`=80, `BLK_W`=64, `ROUNDS`=31.
  - State enum {IDLE, RUN, DRAIN}.
  - S-box/permutation constants, for reuse by the split core.
- One sub-module: `encrypt_v1`, instantiated unchanged in the default build.
  - With the macro, two half-core sub-modules `present_half_core` (rounds 1–15 and 16–31 plus final key addition) replace it.

## Test plan

- Single block: K=0, IV=0, P=0 → `out_data`=5579C1387B228445, `out_last`=1, `blk_cnt`=1, back to IDLE.
- Chaining: K=0, IV=0, P0=0, P1=5579C1387B228445 → C0=C1=5579C1387B228445. This proves C0 is fed back as the chaining value.
- IV applied: K=FFFF…FF, IV=FFFF…FFFF, P=0 → `out_data`=3333DCD3213210D2.
- Backpressure: 4-block chain with `out_ready` toggled 0/1 every cycle.
  - `out_data` is stable while stalled.
  - No drop or duplication.
  - `in_ready` is low whenever `out_valid` & !`out_ready`.
- Reset mid-chain: `rst` asserted after block 2 of 4 → next cycle all outputs at reset values, `busy`=0. A new `start` with K=0, IV=0, P=0 gives 5579C1387B228445.
- Ignored start: `start` pulsed in RUN with a different key → subsequent blocks are still encrypted with the original `key_q`.
